writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage of the 8-bit processor, directly downstream of the execute stage. Captures each valid execute result and commits it: register-file writes (one byte, or two consecutive bytes for multiply/divide), data-memory stores, and the architectural flag register. It also tracks halt and counts retired instructions. It back-pressures execute with `stall` while a two-byte write is in progress.

## Interface
Parameters:
- `NREG`, 8, number of architectural registers; `rd+1` wraps modulo `NREG`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous reset, active-high.
- `valid`  in  1  execute output is valid this cycle (execute `enable`).
- `opcode`  in  5  opcode of the instruction in execute.
- `rd`  in  3  destination register.
- `mem_addr`  in  4  data-memory address for stores.
- `result`  in  16  execute result; `[15:8]` is meaningful only for opcodes 00011 and 00100.
- `zero_in`, `carry_in`, `ac_in`, `parity_in`  in  1 each  flags from execute.
- `stall`  out  1  upstream must hold its inputs; equals (state==HIGH).
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  3  register-file write address.
- `rf_wdata`  out  8  register-file write data.
- `dm_we`  out  1  data-memory write enable.
- `dm_addr`  out  4  data-memory address.
- `dm_wdata`  out  8  data-memory write data.
- `flags`  out  4  architectural flags {zero,carry,ac,parity}.
- `halted`  out  1  sticky halt indicator.
- `retired_count`  out  8  count of retired instructions, wraps at 255->0.

## Operation
- Instruction is accepted on a rising edge when `valid && !stall && !halted`. Inputs are ignored at every other edge.
- Opcode classes:
  - ALU class: 00000, 00001, 00010, 00101-01011, 10000-10101. Write `rd` <= `result[7:0]`.
  - MULDIV class: 00011, 00100. Write `rd` <= `result[7:0]`, then `(rd+1)%NREG` <= `result[15:8]`.
  - STORE: 01100. Performs `dm_we`, with `dm_addr=mem_addr` and `dm_wdata=result[7:0]`. No register write.
  - COMPARE: 11001. No write.
  - JUMP/BRANCH: 01101, 01110, 10110, 10111, 11000. No write.
  - HALT: 11111. Sets `halted`.
  - All other opcodes are no-ops.
- Flags:
  - Load `{zero_in,carry_in,ac_in,parity_in}` on acceptance for 00001-00100, 00101-00110, 00111-01010, 10000-10101 and 11001.
  - Hold for all other opcodes.
- State machine:
  - RUN: accept per the rule above.
    - MULDIV goes to HIGH, latching `result[15:8]` and `(rd+1)%NREG`.
    - HALT goes to HALTED.
    - Everything else stays in RUN.
  - HIGH: issue the high-byte write, then return to RUN. No acceptance.
  - HALTED: terminal until `reset`. No writes; `halted=1`.
- `retired_count`:
  - Increments by 1 per accepted instruction, including no-ops and HALT.
  - For MULDIV it increments at the HIGH cycle rather than on acceptance.
  - 8-bit wrap.

## Timing
- Reset (asynchronous, immediate):
  - State RUN.
  - All outputs 0: `stall`, `rf_we`, `rf_waddr`, `rf_wdata`, `dm_we`, `dm_addr`, `dm_wdata`, `flags`, `halted`, `retired_count`.
- All outputs are registered.
- Latency: acceptance at edge N gives write/store/flag outputs visible after edge N (cycle N+1), valid for exactly one cycle.
- `rf_we` and `dm_we` are single-cycle pulses and are never high together.
- MULDIV accepted at edge N:
  - Cycle N+1: low-byte write, `stall=1`.
  - Cycle N+2: high-byte write, `stall=0`.
  - Next acceptance is possible at edge N+2.
- In HIGH, input changes and `valid` are ignored; the latched high byte is used.
- HALT accepted at edge N: `halted=1` from cycle N+1, with no write strobes. Later `valid` has no effect.
- `reset` during HIGH: the pending high-byte write is dropped; cycle after reset release is RUN.
- With `rd=7` on MULDIV, the high byte goes to register 0.

## Test plan
- Reset mid-stream:
  - After reset, all outputs are 0.
  - Assert `reset` during HIGH: no second `rf_we`, and `stall=0` immediately.
- ADD:
  - Stimulus: opcode 00001, rd=2, result=0x00A5, flags=4'b0100, one `valid` cycle.
  - Response next cycle: `rf_we=1`, waddr=2, wdata=0xA5; `flags=4'b0100`; `retired_count=1`.
- MUL:
  - Stimulus: opcode 00011, rd=7, result=0x1234.
  - Cycle 1: waddr=7 / wdata=0x34, `stall=1`.
  - Cycle 2: waddr=0 / wdata=0x12, `stall=0`.
  - A different input held on `valid` during cycle 1 is not accepted.
- STORE then LOAD:
  - STORE: 01100, mem_addr=0xC, result=0x5A gives `dm_we=1`, `dm_addr=0xC`, `dm_wdata=0x5A`, `rf_we=0`, flags unchanged.
  - LOAD (01011, rd=3, result=0x5A) gives a write of r3=0x5A, flags unchanged.
- Branch/compare:
  - 11001 with flags 4'b1001 updates `flags` with no write.
  - A following 01110 leaves `flags=4'b1001`.
- HALT:
  - 11111 gives `halted=1` next cycle.
  - 10 subsequent valid ADDs produce no strobes and `retired_count` frozen.
  - 256 accepted no-ops wrap `retired_count` to its starting value.

Source files
------------

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits execute results to the register file, data memory
// and flag register, tracks halt and counts retired instructions.
module writeback_stage #(
    parameter int NREG = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [4:0]  opcode,
    input  logic [2:0]  rd,
    input  logic [3:0]  mem_addr,
    input  logic [15:0] result,
    input  logic        zero_in,
    input  logic        carry_in,
    input  logic        ac_in,
    input  logic        parity_in,
    output logic        stall,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic        dm_we,
    output logic [3:0]  dm_addr,
    output logic [7:0]  dm_wdata,
    output logic [3:0]  flags,
    output logic        halted,
    output logic [7:0]  retired_count
);

    typedef enum logic [1:0] {RUN, HIGH, HALTED} state_t;

    state_t      state_reg, state_next;
    logic        rf_we_reg, rf_we_next;
    logic [2:0]  rf_waddr_reg, rf_waddr_next;
    logic [7:0]  rf_wdata_reg, rf_wdata_next;
    logic        dm_we_reg, dm_we_next;
    logic [3:0]  dm_addr_reg, dm_addr_next;
    logic [7:0]  dm_wdata_reg, dm_wdata_next;
    logic [3:0]  flags_reg, flags_next;
    logic [7:0]  count_reg, count_next;
    logic [7:0]  hi_data_reg, hi_data_next;
    logic [2:0]  hi_addr_reg, hi_addr_next;

    logic        is_alu, is_muldiv, is_store, is_halt, is_flag_op;
    logic [2:0]  rd_inc;

    assign is_alu     = (opcode <= 5'd2)
                     || (opcode >= 5'd5  && opcode <= 5'd11)
                     || (opcode >= 5'd16 && opcode <= 5'd21);
    assign is_muldiv  = (opcode == 5'd3) || (opcode == 5'd4);
    assign is_store   = (opcode == 5'd12);
    assign is_halt    = (opcode == 5'd31);
    assign is_flag_op = (opcode >= 5'd1  && opcode <= 5'd10)
                     || (opcode >= 5'd16 && opcode <= 5'd21)
                     || (opcode == 5'd25);

    // Second byte of a multiply/divide lands in the next register, wrapping at NREG.
    assign rd_inc = ({29'd0, rd} == 32'(NREG - 1)) ? 3'd0 : rd + 3'd1;

    always_comb begin
        state_next    = state_reg;
        rf_we_next    = 1'b0;
        rf_waddr_next = rf_waddr_reg;
        rf_wdata_next = rf_wdata_reg;
        dm_we_next    = 1'b0;
        dm_addr_next  = dm_addr_reg;
        dm_wdata_next = dm_wdata_reg;
        flags_next    = flags_reg;
        count_next    = count_reg;
        hi_data_next  = hi_data_reg;
        hi_addr_next  = hi_addr_reg;
        case (state_reg)
            RUN: begin
                if (valid) begin
                    if (is_flag_op)
                        flags_next = {zero_in, carry_in, ac_in, parity_in};
                    if (is_alu || is_muldiv) begin
                        rf_we_next    = 1'b1;
                        rf_waddr_next = rd;
                        rf_wdata_next = result[7:0];
                    end
                    if (is_store) begin
                        dm_we_next    = 1'b1;
                        dm_addr_next  = mem_addr;
                        dm_wdata_next = result[7:0];
                    end
                    // MULDIV retires only once its high byte has been written.
                    if (is_muldiv) begin
                        state_next   = HIGH;
                        hi_data_next = result[15:8];
                        hi_addr_next = rd_inc;
                    end else begin
                        count_next = count_reg + 8'd1;
                    end
                    if (is_halt)
                        state_next = HALTED;
                end
            end
            HIGH: begin
                rf_we_next    = 1'b1;
                rf_waddr_next = hi_addr_reg;
                rf_wdata_next = hi_data_reg;
                count_next    = count_reg + 8'd1;
                state_next    = RUN;
            end
            default: state_next = state_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= RUN;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= 3'd0;
            rf_wdata_reg <= 8'd0;
            dm_we_reg    <= 1'b0;
            dm_addr_reg  <= 4'd0;
            dm_wdata_reg <= 8'd0;
            flags_reg    <= 4'd0;
            count_reg    <= 8'd0;
            hi_data_reg  <= 8'd0;
            hi_addr_reg  <= 3'd0;
        end else begin
            state_reg    <= state_next;
            rf_we_reg    <= rf_we_next;
            rf_waddr_reg <= rf_waddr_next;
            rf_wdata_reg <= rf_wdata_next;
            dm_we_reg    <= dm_we_next;
            dm_addr_reg  <= dm_addr_next;
            dm_wdata_reg <= dm_wdata_next;
            flags_reg    <= flags_next;
            count_reg    <= count_next;
            hi_data_reg  <= hi_data_next;
            hi_addr_reg  <= hi_addr_next;
        end
    end

    assign stall         = (state_reg == HIGH);
    assign halted        = (state_reg == HALTED);
    assign rf_we         = rf_we_reg;
    assign rf_waddr      = rf_waddr_reg;
    assign rf_wdata      = rf_wdata_reg;
    assign dm_we         = dm_we_reg;
    assign dm_addr       = dm_addr_reg;
    assign dm_wdata      = dm_wdata_reg;
    assign flags         = flags_reg;
    assign retired_count = count_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, hand-written multi-cycle
// sequences and randomized traffic checked against a behavioural model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [4:0]  opcode = '0;
    logic [2:0]  rd = '0;
    logic [3:0]  mem_addr = '0;
    logic [15:0] result = '0;
    logic        zero_in = 1'b0, carry_in = 1'b0, ac_in = 1'b0, parity_in = 1'b0;
    logic        stall, rf_we, dm_we, halted;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata, dm_wdata, retired_count;
    logic [3:0]  dm_addr, flags;

    writeback_stage #(.NREG(8)) dut (
        .clk(clk), .reset(reset), .valid(valid), .opcode(opcode), .rd(rd),
        .mem_addr(mem_addr), .result(result), .zero_in(zero_in), .carry_in(carry_in),
        .ac_in(ac_in), .parity_in(parity_in), .stall(stall), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .flags(flags), .halted(halted), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: an outstanding high byte, a halt flag, a retire count.
    bit         m_pend, m_halted;
    int         m_hi, m_hi_addr, m_count, m_flags;
    bit         e_rf_we, e_dm_we;
    int         e_waddr, e_wdata, e_dm_addr, e_dm_wdata;

    task automatic model_reset();
        m_pend = 0; m_halted = 0; m_hi = 0; m_hi_addr = 0; m_count = 0; m_flags = 0;
        e_rf_we = 0; e_dm_we = 0; e_waddr = 0; e_wdata = 0; e_dm_addr = 0; e_dm_wdata = 0;
    endtask

    task automatic model_edge();
        int op;
        op = int'(opcode);
        e_rf_we = 0;
        e_dm_we = 0;
        if (m_pend) begin
            e_rf_we = 1; e_waddr = m_hi_addr; e_wdata = m_hi;
            m_count = (m_count + 1) % 256;
            m_pend = 0;
        end else if (!m_halted && valid) begin
            if (op inside {[1:10], [16:21], 25})
                m_flags = {zero_in, carry_in, ac_in, parity_in};
            if (op inside {[0:11], [16:21]}) begin
                e_rf_we = 1; e_waddr = int'(rd); e_wdata = int'(result[7:0]);
            end
            if (op == 12) begin
                e_dm_we = 1; e_dm_addr = int'(mem_addr); e_dm_wdata = int'(result[7:0]);
            end
            if (op == 3 || op == 4) begin
                m_pend = 1; m_hi = int'(result[15:8]); m_hi_addr = (int'(rd) + 1) % 8;
            end else begin
                m_count = (m_count + 1) % 256;
            end
            if (op == 31) m_halted = 1;
        end
    endtask

    task automatic check_model();
        chk("stall", 32'(stall), 32'(m_pend));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("retired_count", 32'(retired_count), 32'(m_count));
        chk("flags", 32'(flags), 32'(m_flags));
        chk("rf_we", 32'(rf_we), 32'(e_rf_we));
        chk("dm_we", 32'(dm_we), 32'(e_dm_we));
        if (e_rf_we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e_waddr));
            chk("rf_wdata", 32'(rf_wdata), 32'(e_wdata));
        end
        if (e_dm_we) begin
            chk("dm_addr", 32'(dm_addr), 32'(e_dm_addr));
            chk("dm_wdata", 32'(dm_wdata), 32'(e_dm_wdata));
        end
    endtask

    task automatic drive(input bit v, input int op, input int r, input int a,
                         input int res, input int fl);
        valid = v; opcode = 5'(op); rd = 3'(r); mem_addr = 4'(a); result = 16'(res);
        zero_in = fl[3]; carry_in = fl[2]; ac_in = fl[1]; parity_in = fl[0];
    endtask

    // Called at a negedge: one rising edge, then outputs checked at the next negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        valid = 1'b0;
        #1;
        chk("rst stall", 32'(stall), 0);
        chk("rst rf_we", 32'(rf_we), 0);
        chk("rst rf_waddr", 32'(rf_waddr), 0);
        chk("rst rf_wdata", 32'(rf_wdata), 0);
        chk("rst dm_we", 32'(dm_we), 0);
        chk("rst dm_addr", 32'(dm_addr), 0);
        chk("rst dm_wdata", 32'(dm_wdata), 0);
        chk("rst flags", 32'(flags), 0);
        chk("rst halted", 32'(halted), 0);
        chk("rst retired_count", 32'(retired_count), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        int op, rd, addr, res, fl;
        bit rf_we;
        int waddr, wdata;
        bit dm_we;
        int dm_addr, dm_wdata, flags, count;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int c0;
        model_reset();

        tbl[0] = '{1,  2, 0,   'h00A5, 'b0100, 1, 2, 'hA5, 0, 0,   0,     'b0100, 1};
        tbl[1] = '{12, 0, 'hC, 'h005A, 'b1111, 0, 0, 0,    1, 'hC, 'h5A,  'b0100, 2};
        tbl[2] = '{11, 3, 0,   'h005A, 'b1111, 1, 3, 'h5A, 0, 0,   0,     'b0100, 3};
        tbl[3] = '{25, 6, 0,   'h00FF, 'b1001, 0, 0, 0,    0, 0,   0,     'b1001, 4};
        tbl[4] = '{14, 6, 0,   'h00FF, 'b0110, 0, 0, 0,    0, 0,   0,     'b1001, 5};
        tbl[5] = '{0,  1, 0,   'h0077, 'b1111, 1, 1, 'h77, 0, 0,   0,     'b1001, 6};
        tbl[6] = '{15, 4, 0,   'h0033, 'b0000, 0, 0, 0,    0, 0,   0,     'b1001, 7};
        tbl[7] = '{2,  5, 0,   'h990C, 'b0011, 1, 5, 'h0C, 0, 0,   0,     'b0011, 8};

        repeat (2) @(negedge clk);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            drive(1, tbl[i].op, tbl[i].rd, tbl[i].addr, tbl[i].res, tbl[i].fl);
            cycle();
            chk($sformatf("vec%0d rf_we", i), 32'(rf_we), 32'(tbl[i].rf_we));
            if (tbl[i].rf_we) begin
                chk($sformatf("vec%0d rf_waddr", i), 32'(rf_waddr), 32'(tbl[i].waddr));
                chk($sformatf("vec%0d rf_wdata", i), 32'(rf_wdata), 32'(tbl[i].wdata));
            end
            chk($sformatf("vec%0d dm_we", i), 32'(dm_we), 32'(tbl[i].dm_we));
            if (tbl[i].dm_we) begin
                chk($sformatf("vec%0d dm_addr", i), 32'(dm_addr), 32'(tbl[i].dm_addr));
                chk($sformatf("vec%0d dm_wdata", i), 32'(dm_wdata), 32'(tbl[i].dm_wdata));
            end
            chk($sformatf("vec%0d flags", i), 32'(flags), 32'(tbl[i].flags));
            chk($sformatf("vec%0d count", i), 32'(retired_count), 32'(tbl[i].count));
        end

        // MUL with rd=7: high byte wraps to r0; a different input during HIGH is ignored.
        drive(1, 3, 7, 0, 'h1234, 'b1010);
        cycle();
        chk("mul lo rf_we", 32'(rf_we), 1);
        chk("mul lo waddr", 32'(rf_waddr), 7);
        chk("mul lo wdata", 32'(rf_wdata), 'h34);
        chk("mul lo stall", 32'(stall), 1);
        chk("mul lo count", 32'(retired_count), 8);
        drive(1, 1, 4, 0, 'h00FF, 'b0001);
        cycle();
        chk("mul hi rf_we", 32'(rf_we), 1);
        chk("mul hi waddr", 32'(rf_waddr), 0);
        chk("mul hi wdata", 32'(rf_wdata), 'h12);
        chk("mul hi stall", 32'(stall), 0);
        chk("mul hi count", 32'(retired_count), 9);
        chk("mul flags", 32'(flags), 'b1010);
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        chk("mul ignored rf_we", 32'(rf_we), 0);
        chk("mul ignored count", 32'(retired_count), 9);

        // Randomized traffic against the model (HALT excluded here).
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 30);
            drive($urandom_range(0, 3) != 0, op, $urandom_range(0, 7), $urandom_range(0, 15),
                  $urandom_range(0, 65535), $urandom_range(0, 15));
            cycle();
        end

        // Reset during HIGH drops the pending high byte.
        drive(1, 4, 2, 0, 'hBEEF, 'b0110);
        cycle();
        chk("rsthigh stall before", 32'(stall), 1);
        reset = 1'b1;
        valid = 1'b0;
        #1;
        chk("rsthigh stall", 32'(stall), 0);
        chk("rsthigh rf_we", 32'(rf_we), 0);
        chk("rsthigh count", 32'(retired_count), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        chk("rsthigh no hi write", 32'(rf_we), 0);

        // 256 accepted no-ops return the counter to its starting value.
        drive(1, 1, 1, 0, 'h11, 'b0000);
        cycle();
        c0 = m_count;
        for (int i = 0; i < 256; i++) begin
            drive(1, 15, i % 8, 0, i, 0);
            cycle();
        end
        chk("wrap count", 32'(retired_count), 32'(c0));

        // HALT then valid ADDs: no strobes, frozen count.
        drive(1, 31, 0, 0, 0, 'b1111);
        cycle();
        chk("halt halted", 32'(halted), 1);
        chk("halt count", 32'(retired_count), 32'((c0 + 1) % 256));
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, i % 8, 0, $urandom_range(0, 255), $urandom_range(0, 15));
            cycle();
            chk("halted rf_we", 32'(rf_we), 0);
            chk("halted dm_we", 32'(dm_we), 0);
            chk("halted count", 32'(retired_count), 32'((c0 + 1) % 256));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
